limb_carry_norm_18: RTL and testbench
=====================================

LIMB_CARRY_NORM_18 -- requirements
Module: limb_carry_norm_18

Interface
REQ-001 Parameter CNT_W, default 8: width of the output limb index counter.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 sclr  in  1  reset, synchronous and active-high.
REQ-004 in_valid  in  1  in_p/in_last carry a product beat.
REQ-005 in_ready  out  1  block accepts the beat this cycle.
REQ-006 in_p  in  36  unsigned partial product, same format as the upstream 18x18+18 multiply-add output.
REQ-007 in_last  in  1  final beat of the current operand frame.
REQ-008 out_valid  out  1  out_limb and its flags are valid.
REQ-009 out_ready  in  1  consumer accepts the output limb this cycle.
REQ-010 out_limb  out  18  normalised result limb, least significant limb first.
REQ-011 out_idx  out  CNT_W  limb position within the frame, starting at 0.
REQ-012 out_last  out  1  final limb of the frame.
REQ-013 ovf  out  1  carry lost at the end of the frame; valid only with out_last.

Function
REQ-014 The block shall hold a 19-bit carry register, cleared at the start of every frame.
REQ-015 On accept, meaning in_valid && in_ready: sum = in_p + carry, computed at 37 bits; out_limb <= sum[17:0]; carry <= sum[36:18], which always fits in 19 bits.
REQ-016 Latency shall be 1 cycle from accept to out_valid, with a single output register and no internal FIFO.
REQ-017 in_ready shall equal (state != FLUSH) && (!out_valid || out_ready), so full-rate streaming works with no bubbles.
REQ-018 While out_valid=1 and out_ready=0, out_limb, out_idx, out_last and ovf shall hold stable.
REQ-019 out_valid shall fall after an output handshake unless a new beat is accepted in the same cycle.
REQ-020 out_idx shall increment per emitted limb, wrap from 2^CNT_W-1 to 0 with no flag, and reset to 0 after the out_last limb.
REQ-021 FSM states:
- IDLE: no frame open, carry=0.
- RUN: frame open.
- FLUSH: emitting the final carry limb.
REQ-022 FSM transitions:
- IDLE to RUN on an accept with in_last=0.
- RUN to RUN on an accept with in_last=0.
- IDLE or RUN to FLUSH, or directly to IDLE, on an accept with in_last=1 (see Configuration).
- FLUSH to IDLE on the flush-limb handshake.
REQ-023 A single-beat frame, meaning in_last=1 on the first beat, shall be legal.
REQ-024 If out_ready is held low indefinitely, no input shall be lost, because in_ready stays low.

Reset
REQ-025 On sclr=1, regardless of handshake state:
- state <= IDLE, carry <= 0, out_idx <= 0.
- out_valid <= 0, out_limb <= 0, out_last <= 0, ovf <= 0.
- In-flight data shall be discarded.
REQ-026 in_ready shall be 1 in the cycle after sclr deasserts.

Configuration
REQ-027 Macro LIMB_CARRY_NORM_FLUSH_EN shall select end-of-frame carry handling.
REQ-028 With LIMB_CARRY_NORM_FLUSH_EN defined:
- The in_last beat emits its limb with out_last=0, and the FSM enters FLUSH.
- FLUSH emits out_limb=carry[17:0], out_last=1, ovf=carry[18], then clears carry.
REQ-029 Without LIMB_CARRY_NORM_FLUSH_EN:
- The in_last beat's limb carries out_last=1 and ovf=|sum[36:18]; the carry is dropped and cleared.
- The FLUSH state shall not exist.

Structure
REQ-030 Constants LIMB_W=18, PROD_W=36 and CARRY_W=19, plus the FSM state enum, shall live in shared package mult_add_pkg, used by the multiply-add stage as well.
REQ-031 The block shall be a single module; no sub-module is warranted.

Verification
REQ-032 With FLUSH_EN, a single beat in_p=36'h0_0004_0005 with in_last=1 shall produce limb 0x00005 (idx0, last=0), then limb 0x00001 (idx1, last=1, ovf=0).
REQ-033 With FLUSH_EN, beats 36'hF_FFFF_FFFF then 36'h0 with last=1 shall produce limbs 0x3FFFF, 0x3FFFF, 0x00000 (last=1, ovf=0).
REQ-034 Without FLUSH_EN, in_p=36'h0_0004_0005 with last=1 shall produce limb 0x00005 with out_last=1 and ovf=1.
REQ-035 With out_ready=0 for 3 cycles mid-frame, outputs shall stay stable, in_ready=0, and no beat shall be lost; with continuous valid and ready, throughput shall be 1 limb per cycle.
REQ-036 sclr asserted in RUN with carry!=0 and out_valid=1 shall give out_valid=0 next cycle; the following frame with in_p=36'h7 shall output limb 0x00007 at idx0.
REQ-037 A 257-beat frame with CNT_W=8 shall wrap out_idx from 255 to 0, and out_last shall appear only on the final limb.

Source files
------------

// File: rtl/mult_add_pkg.sv
// Constants and FSM state type shared by the 18x18+18 multiply-add stage and the limb carry normaliser.
// LIMB_CARRY_NORM_FLUSH_EN adds the FLUSH state used for end-of-frame carry emission.
package mult_add_pkg;

  localparam int LIMB_W  = 18;
  localparam int PROD_W  = 36;
  localparam int CARRY_W = 19;

`ifdef LIMB_CARRY_NORM_FLUSH_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } norm_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } norm_state_t;
`endif

endpackage

// File: rtl/limb_carry_norm_18.sv
// Folds a stream of 36-bit partial products into 18-bit limbs with carry propagation, LS limb first.
// Define LIMB_CARRY_NORM_FLUSH_EN to emit the final carry as an extra limb instead of reporting it as ovf.
module limb_carry_norm_18
  import mult_add_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_p,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_limb,
  output logic [CNT_W-1:0]  out_idx,
  output logic              out_last,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  // Handshake: a beat transfers on a rising clk edge where valid && ready;
  // valid never waits on ready, and the producer holds its payload stable while valid && !ready.

  norm_state_t         state_q, state_d;
  logic [CARRY_W-1:0]  carry_q, carry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [LIMB_W-1:0]   out_limb_q, out_limb_d;
  logic [CNT_W-1:0]    out_idx_q, out_idx_d;
  logic                out_last_q, out_last_d;
  logic                ovf_q, ovf_d;

  logic [PROD_W:0]     sum;
  logic                out_free;
  logic                in_ready_int;
  logic                accept;

  always_comb begin
    sum      = {1'b0, in_p} + {{(PROD_W + 1 - CARRY_W){1'b0}}, carry_q};
    out_free = !out_valid_q || out_ready;
`ifdef LIMB_CARRY_NORM_FLUSH_EN
    in_ready_int = (state_q != FLUSH) && out_free;
`else
    in_ready_int = out_free;
`endif
    accept = in_valid && in_ready_int;

    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_limb_d  = out_limb_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_limb_d  = sum[LIMB_W-1:0];
      out_idx_d   = cnt_q;
      out_last_d  = 1'b0;
      ovf_d       = 1'b0;
      carry_d     = sum[PROD_W:LIMB_W];
      cnt_d       = cnt_q + CNT_W'(1);
      state_d     = RUN;
      if (in_last) begin
`ifdef LIMB_CARRY_NORM_FLUSH_EN
        state_d    = FLUSH;
`else
        out_last_d = 1'b1;
        ovf_d      = |sum[PROD_W:LIMB_W];
        carry_d    = '0;
        cnt_d      = '0;
        state_d    = IDLE;
`endif
      end
    end

`ifdef LIMB_CARRY_NORM_FLUSH_EN
    // The flush limb is the only limb with out_last set; leave FLUSH once it is taken.
    if (state_q == FLUSH) begin
      if (out_valid_q && out_last_q) begin
        if (out_ready) state_d = IDLE;
      end else if (out_free) begin
        out_valid_d = 1'b1;
        out_limb_d  = carry_q[LIMB_W-1:0];
        out_idx_d   = cnt_q;
        out_last_d  = 1'b1;
        ovf_d       = carry_q[CARRY_W-1];
        carry_d     = '0;
        cnt_d       = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q     <= IDLE;
      carry_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_limb_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_limb_q  <= out_limb_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_int;
  assign out_valid = out_valid_q;
  assign out_limb  = out_limb_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_limb_carry_norm_18.sv
// Directed bench for limb_carry_norm_18: hand-computed limb sequences checked through an expected queue.
// Expectations follow LIMB_CARRY_NORM_FLUSH_EN when it is defined for the build.
module tb_limb_carry_norm_18;

  localparam int CNT_W = 8;
  localparam int EXP_W = 18 + CNT_W + 2;

  logic              clk = 1'b0;
  logic              sclr = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [35:0]       in_p = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [17:0]       out_limb;
  logic [CNT_W-1:0]  out_idx;
  logic              out_last;
  logic              ovf;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [EXP_W-1:0] exp_q[$];

  limb_carry_norm_18 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .sclr      (sclr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_limb  (out_limb),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [EXP_W-1:0] pack(input logic [17:0] limb, input int idx,
                                            input logic last, input logic o);
    logic [CNT_W-1:0] i;
    i = idx[CNT_W-1:0];
    return {limb, i, last, o};
  endfunction

  // scoreboard: every output handshake pops one expected limb
  always @(negedge clk) begin
    if (!sclr && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_limb", {out_limb, out_idx, out_last, ovf}, '0);
      end else begin
        check("limb", {out_limb, out_idx, out_last, ovf}, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [35:0] p, input logic last);
    bit got = 0;
    in_valid = 1'b1;
    in_p     = p;
    in_last  = last;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      check("in_ready_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    sclr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sclr = 1'b0;
  endtask

  initial begin
    int t0;
    do_reset();
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", {out_limb, out_idx, out_last, ovf}, '0);
    @(posedge clk);
    #1;

    // single beat 0x4_0005: limb 5, carry 1
`ifdef LIMB_CARRY_NORM_FLUSH_EN
    exp_q.push_back(pack(18'h00005, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(18'h00001, 1, 1'b1, 1'b0));
`else
    exp_q.push_back(pack(18'h00005, 0, 1'b1, 1'b1));
`endif
    send(36'h0_0004_0005, 1'b1);
    drain();

    // all-ones then zero: carry 0x3FFFF fully absorbed
    exp_q.push_back(pack(18'h3FFFF, 0, 1'b0, 1'b0));
`ifdef LIMB_CARRY_NORM_FLUSH_EN
    exp_q.push_back(pack(18'h3FFFF, 1, 1'b0, 1'b0));
    exp_q.push_back(pack(18'h00000, 2, 1'b1, 1'b0));
`else
    exp_q.push_back(pack(18'h3FFFF, 1, 1'b1, 1'b0));
`endif
    send(36'hF_FFFF_FFFF, 1'b0);
    send(36'h0, 1'b1);
    drain();

    // all-ones twice: final sum 0x10_0003_FFFE, carry out 0x40000
    exp_q.push_back(pack(18'h3FFFF, 0, 1'b0, 1'b0));
`ifdef LIMB_CARRY_NORM_FLUSH_EN
    exp_q.push_back(pack(18'h3FFFE, 1, 1'b0, 1'b0));
    exp_q.push_back(pack(18'h00000, 2, 1'b1, 1'b1));
`else
    exp_q.push_back(pack(18'h3FFFE, 1, 1'b1, 1'b1));
`endif
    send(36'hF_FFFF_FFFF, 1'b0);
    send(36'hF_FFFF_FFFF, 1'b1);
    drain();

    // back-pressure mid-frame for 3 cycles
    exp_q.push_back(pack(18'h00005, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(18'h00011, 1, 1'b0, 1'b0));
`ifdef LIMB_CARRY_NORM_FLUSH_EN
    exp_q.push_back(pack(18'h00003, 2, 1'b0, 1'b0));
    exp_q.push_back(pack(18'h00000, 3, 1'b1, 1'b0));
`else
    exp_q.push_back(pack(18'h00003, 2, 1'b1, 1'b0));
`endif
    send(36'h0_0004_0005, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_p      = 36'h10;
    in_last   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_hold", {out_valid, out_limb, out_idx, out_last, ovf},
            {1'b1, pack(18'h00005, 0, 1'b0, 1'b0)});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(36'h10, 1'b0);
    send(36'h3, 1'b1);
    drain();

    // full-rate streaming: 8 beats in 8 cycles
    for (int i = 0; i < 8; i++)
      exp_q.push_back(pack(18'(i + 1), i, (i == 7) ? 1'b1 : 1'b0, 1'b0));
`ifdef LIMB_CARRY_NORM_FLUSH_EN
    exp_q[7] = pack(18'd8, 7, 1'b0, 1'b0);
    exp_q.push_back(pack(18'h00000, 8, 1'b1, 1'b0));
`endif
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(36'(i + 1), (i == 7) ? 1'b1 : 1'b0);
    check("throughput_cycles", 64'(cyc - t0), 64'd8);
    drain();

    // reset mid-frame with carry and a held output limb
    out_ready = 1'b0;
    send(36'h0_0004_0005, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
`ifdef LIMB_CARRY_NORM_FLUSH_EN
    exp_q.push_back(pack(18'h00007, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(18'h00000, 1, 1'b1, 1'b0));
`else
    exp_q.push_back(pack(18'h00007, 0, 1'b1, 1'b0));
`endif
    send(36'h7, 1'b1);
    drain();

    // 257-beat frame: out_idx wraps 255 -> 0, out_last only at the end
    for (int i = 0; i < 257; i++)
      exp_q.push_back(pack(18'(i), i, (i == 256) ? 1'b1 : 1'b0, 1'b0));
`ifdef LIMB_CARRY_NORM_FLUSH_EN
    exp_q[256] = pack(18'd256, 256, 1'b0, 1'b0);
    exp_q.push_back(pack(18'h00000, 257, 1'b1, 1'b0));
`endif
    for (int i = 0; i < 257; i++) send(36'(i), (i == 256) ? 1'b1 : 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
